serial_word_tx: RTL and testbench

//   Parallel-in/serial-out transmitter feeding the serial input d of the downstream

---
 rtl/serial_word_tx.sv | 163 ++++++++++++++++
 tb/tb_serial_word_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_tx
// Description : Sends WIDTH-bit words MSB-first, one bit per clock, to a
//               downstream serial shift register. Words arrive on a
//               valid/ready handshake. Optional macro PARITY_EN adds one
//               even-parity bit after each word.
// Revision    : 1.0  initial release
// ============================================================================
module serial_word_tx #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             d,
    output logic             d_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_cnt_init = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [3:0]    c_gap_init = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam state_t        c_post_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
    localparam logic          c_post_busy  = (GAP_CYCLES > 0);
`ifdef PARITY_EN
    localparam logic          c_parity = 1'b1;
`else
    localparam logic          c_parity = 1'b0;
`endif

    state_t           r_state;
    logic [WIDTH-2:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gap;
    logic             r_run;
    logic             r_d;
    logic             r_d_valid;
    logic             r_busy;
    logic             r_word_done;
`ifdef PARITY_EN
    logic             r_par;
`endif

    logic w_last_bit;
    logic w_ready;
    logic w_accept;

`ifdef PARITY_EN
    assign w_last_bit = (r_state == ST_PAR);
`else
    assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == '0);
`endif

    // With no gap configured, the final bit cycle also accepts so words stream back to back.
    assign w_ready  = r_run && ((r_state == ST_IDLE) || ((GAP_CYCLES == 0) && w_last_bit));
    assign w_accept = din_valid && w_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_run       <= 1'b0;
            r_d         <= 1'b0;
            r_d_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_word_done <= 1'b0;
`ifdef PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_run       <= 1'b1;
            r_word_done <= 1'b0;
            if (w_accept) begin
                // The MSB goes straight to d; the remaining bits queue in r_shift.
                r_state   <= ST_SHIFT;
                r_shift   <= din[WIDTH-2:0];
                r_cnt     <= c_cnt_init;
                r_d       <= din[WIDTH-1];
                r_d_valid <= 1'b1;
                r_busy    <= 1'b1;
`ifdef PARITY_EN
                r_par     <= ^din;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_d       <= 1'b0;
                        r_d_valid <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                    ST_SHIFT: begin
                        if (r_cnt != '0) begin
                            r_cnt       <= r_cnt - c_cnt_one;
                            r_shift     <= r_shift << 1;
                            r_d         <= r_shift[WIDTH-2];
                            r_word_done <= (r_cnt == c_cnt_one) && !c_parity;
                        end else begin
`ifdef PARITY_EN
                            r_state     <= ST_PAR;
                            r_d         <= r_par;
                            r_d_valid   <= 1'b1;
                            r_word_done <= 1'b1;
`else
                            r_state     <= c_post_state;
                            r_busy      <= c_post_busy;
                            r_gap       <= c_gap_init;
                            r_d         <= 1'b0;
                            r_d_valid   <= 1'b0;
`endif
                        end
                    end
                    ST_PAR: begin
                        r_state   <= c_post_state;
                        r_busy    <= c_post_busy;
                        r_gap     <= c_gap_init;
                        r_d       <= 1'b0;
                        r_d_valid <= 1'b0;
                    end
                    ST_GAP: begin
                        r_d       <= 1'b0;
                        r_d_valid <= 1'b0;
                        if (r_gap == 4'd0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gap <= r_gap - 4'd1;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_d       <= 1'b0;
                        r_d_valid <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign din_ready = w_ready;
    assign d         = r_d;
    assign d_valid   = r_d_valid;
    assign busy      = r_busy;
    assign word_done = r_word_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_tx
// Description : Bench for serial_word_tx; two instances (4-bit no gap, 6-bit
//               two-cycle gap) compared each cycle against a bit-stream model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_word_tx;

    localparam int WA = 4;
    localparam int GA = 0;
    localparam int WB = 6;
    localparam int GB = 2;
`ifdef PARITY_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;

    logic rdy_a, d_a, dv_a, busy_a, done_a;
    logic rdy_b, d_b, dv_b, busy_b, done_b;
    logic [3:0] sr_a = '0;

    int checks = 0;
    int passed = 0;

    // Model: remaining stream bits per instance, MSB of the remaining span is current.
    logic [15:0] m_s [2];
    int          m_rem [2];
    int          m_gap [2];
    bit          m_run [2];

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(WA), .GAP_CYCLES(GA)) u_dut_a (
        .clk(clk), .rstn(rstn), .din(din[WA-1:0]), .din_valid(din_valid),
        .din_ready(rdy_a), .d(d_a), .d_valid(dv_a), .busy(busy_a), .word_done(done_a)
    );

    serial_word_tx #(.WIDTH(WB), .GAP_CYCLES(GB)) u_dut_b (
        .clk(clk), .rstn(rstn), .din(din[WB-1:0]), .din_valid(din_valid),
        .din_ready(rdy_b), .d(d_b), .d_valid(dv_b), .busy(busy_b), .word_done(done_b)
    );

    // Stand-in for the downstream left-shift register fed by instance A.
    always @(posedge clk) if (dv_a) sr_a <= {sr_a[2:0], d_a};

    // Expected {d_valid, d, word_done, busy, din_ready}.
    function automatic logic [4:0] exp_vec(input int i);
        int   g;
        logic dv, db, dn, bz, rd;
        g  = (i == 0) ? GA : GB;
        dv = (m_rem[i] > 0);
        db = dv ? m_s[i][m_rem[i]-1] : 1'b0;
        dn = (m_rem[i] == 1);
        bz = (m_rem[i] > 0) || (m_gap[i] > 0);
        rd = m_run[i] && (((m_rem[i] == 0) && (m_gap[i] == 0)) || ((g == 0) && (m_rem[i] == 1)));
        return {dv, db, dn, bz, rd};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0;
            m_gap[i] = 0;
            m_run[i] = 1'b0;
            m_s[i]   = '0;
        end
    endtask

    task automatic model_edge();
        logic [4:0]  e;
        logic [15:0] xm;
        int          w, g;
        bit          acc;
        for (int i = 0; i < 2; i++) begin
            if (!rstn) continue;
            w   = (i == 0) ? WA : WB;
            g   = (i == 0) ? GA : GB;
            e   = exp_vec(i);
            acc = din_valid && e[0];
            if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0 && !acc && g > 0) m_gap[i] = g;
            end else if (m_gap[i] > 0) begin
                m_gap[i]--;
            end
            if (acc) begin
                xm       = din & ((16'd1 << w) - 16'd1);
                m_s[i]   = (PE != 0) ? ((xm << 1) | {15'd0, ^xm}) : xm;
                m_rem[i] = w + PE;
            end
            m_run[i] = 1'b1;
        end
    endtask

    task automatic advance(input logic v, input logic [15:0] x);
        din_valid = v;
        din       = x;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({dv_a, d_a, done_a, busy_a, rdy_a} !== 5'b0 || {dv_b, d_b, done_b, busy_b, rdy_b} !== 5'b0)
                $display("FAIL reset_state: got a=%b b=%b want 00000", {dv_a, d_a, done_a, busy_a, rdy_a},
                         {dv_b, d_b, done_b, busy_b, rdy_b});
            else passed++;
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (rdy_a !== 1'b0) $display("FAIL reset_release_ready: got %b want 0", rdy_a);
        else passed++;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 10; k++) begin
            advance(1'b0, 16'($urandom));
            checks++;
            if ({dv_a, d_a, done_a, busy_a, rdy_a} !== exp_vec(0))
                $display("FAIL idle_a cyc %0d: got %b want %b", k, {dv_a, d_a, done_a, busy_a, rdy_a}, exp_vec(0));
            else passed++;
            checks++;
            if ({dv_b, d_b, done_b, busy_b, rdy_b} !== exp_vec(1))
                $display("FAIL idle_b cyc %0d: got %b want %b", k, {dv_b, d_b, done_b, busy_b, rdy_b}, exp_vec(1));
            else passed++;
        end
    endtask

    task automatic test_single_word();
        logic [3:0] w = 4'b1011;
        logic [3:0] sr_exp;
        sr_exp = (PE != 0) ? {w[2:0], ^w} : w;
        for (int n = 0; n < 11; n++) begin
            for (int k = 0; k < 12; k++) begin
                if (n == 0) advance(k == 0, 16'h000B);
                else        advance(k == 0, 16'($urandom));
                checks++;
                if ({dv_a, d_a, done_a, busy_a, rdy_a} !== exp_vec(0))
                    $display("FAIL single_a w%0d cyc %0d: got %b want %b", n, k, {dv_a, d_a, done_a, busy_a, rdy_a}, exp_vec(0));
                else passed++;
                checks++;
                if ({dv_b, d_b, done_b, busy_b, rdy_b} !== exp_vec(1))
                    $display("FAIL single_b w%0d cyc %0d: got %b want %b", n, k, {dv_b, d_b, done_b, busy_b, rdy_b}, exp_vec(1));
                else passed++;
                if (n == 0 && k == WA + PE) begin
                    checks++;
                    if (sr_a !== sr_exp) $display("FAIL downstream_out: got %b want %b", sr_a, sr_exp);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            if (k == 0)      advance(1'b1, 16'h000A);
            else if (k < 5)  advance(1'b1, 16'h0005);
            else             advance(1'b0, 16'h0000);
            checks++;
            if ({dv_a, d_a, done_a, busy_a, rdy_a} !== exp_vec(0))
                $display("FAIL b2b_dir_a cyc %0d: got %b want %b", k, {dv_a, d_a, done_a, busy_a, rdy_a}, exp_vec(0));
            else passed++;
            checks++;
            if ({dv_b, d_b, done_b, busy_b, rdy_b} !== exp_vec(1))
                $display("FAIL b2b_dir_b cyc %0d: got %b want %b", k, {dv_b, d_b, done_b, busy_b, rdy_b}, exp_vec(1));
            else passed++;
        end
        for (int k = 0; k < 60; k++) begin
            advance(1'b1, 16'($urandom));
            checks++;
            if ({dv_a, d_a, done_a, busy_a, rdy_a} !== exp_vec(0))
                $display("FAIL b2b_rnd_a cyc %0d: got %b want %b", k, {dv_a, d_a, done_a, busy_a, rdy_a}, exp_vec(0));
            else passed++;
            checks++;
            if ({dv_b, d_b, done_b, busy_b, rdy_b} !== exp_vec(1))
                $display("FAIL b2b_rnd_b cyc %0d: got %b want %b", k, {dv_b, d_b, done_b, busy_b, rdy_b}, exp_vec(1));
            else passed++;
        end
        for (int k = 0; k < 12; k++) advance(1'b0, 16'h0000);
    endtask

    task automatic test_reset_midword();
        for (int k = 0; k < 20; k++) begin
            if (k == 2) begin
                rstn = 1'b0;
                model_clear();
                #1;
                checks++;
                if ({dv_a, d_a, done_a, busy_a, rdy_a} !== 5'b0 || {dv_b, d_b, done_b, busy_b, rdy_b} !== 5'b0)
                    $display("FAIL midword_async_reset: got a=%b b=%b want 00000",
                             {dv_a, d_a, done_a, busy_a, rdy_a}, {dv_b, d_b, done_b, busy_b, rdy_b});
                else passed++;
            end
            if (k == 4) rstn = 1'b1;
            if (k == 0)      advance(1'b1, 16'h000C);
            else if (k == 5) advance(1'b1, 16'h0006);
            else             advance(1'b0, 16'h0000);
            checks++;
            if ({dv_a, d_a, done_a, busy_a, rdy_a} !== exp_vec(0))
                $display("FAIL midword_a cyc %0d: got %b want %b", k, {dv_a, d_a, done_a, busy_a, rdy_a}, exp_vec(0));
            else passed++;
            checks++;
            if ({dv_b, d_b, done_b, busy_b, rdy_b} !== exp_vec(1))
                $display("FAIL midword_b cyc %0d: got %b want %b", k, {dv_b, d_b, done_b, busy_b, rdy_b}, exp_vec(1));
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (!rstn) rstn = 1'b1;
            else if ($urandom_range(0, 99) < 2) begin
                rstn = 1'b0;
                model_clear();
            end
            advance($urandom_range(0, 1) == 1, 16'($urandom));
            checks++;
            if ({dv_a, d_a, done_a, busy_a, rdy_a} !== exp_vec(0))
                $display("FAIL random_a cyc %0d: got %b want %b", k, {dv_a, d_a, done_a, busy_a, rdy_a}, exp_vec(0));
            else passed++;
            checks++;
            if ({dv_b, d_b, done_b, busy_b, rdy_b} !== exp_vec(1))
                $display("FAIL random_b cyc %0d: got %b want %b", k, {dv_b, d_b, done_b, busy_b, rdy_b}, exp_vec(1));
            else passed++;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_idle();
        test_single_word();
        test_back_to_back();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
